// File: rtl/pipe_stage_elastic_pkg.sv
// Shared pipeline definitions: stage-bundle widths, field offsets
// and NOP bundles used to seed each elastic stage register.
package rv_pipe_pkg;

  localparam int XLEN = 32;
  localparam int RW = 5;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    CT_NONE = 3'd0,
    CT_ALU = 3'd1,
    CT_LOAD = 3'd2,
    CT_STORE = 3'd3,
    CT_BRANCH = 3'd4,
    CT_JUMP = 3'd5
  } ctrl_e;

  // F/D: {pc, instr}
  localparam int FD_INSTR_LSB = 0;
  localparam int FD_PC_LSB = FD_INSTR_LSB + XLEN;
  localparam int FD_W = FD_PC_LSB + XLEN;

  // D/E: {ctrl, pc, instr, rs1v, rs2v, imm, rs1, rs2, rd}
  localparam int DE_RD_LSB = 0;
  localparam int DE_RS2_LSB = DE_RD_LSB + RW;
  localparam int DE_RS1_LSB = DE_RS2_LSB + RW;
  localparam int DE_IMM_LSB = DE_RS1_LSB + RW;
  localparam int DE_RS2V_LSB = DE_IMM_LSB + XLEN;
  localparam int DE_RS1V_LSB = DE_RS2V_LSB + XLEN;
  localparam int DE_INSTR_LSB = DE_RS1V_LSB + XLEN;
  localparam int DE_PC_LSB = DE_INSTR_LSB + XLEN;
  localparam int DE_CTRL_LSB = DE_PC_LSB + XLEN;
  localparam int DE_W = 3 + XLEN * 5 + RW * 3;

  // E/M: {ctrl, alu, store data, rd}
  localparam int EM_RD_LSB = 0;
  localparam int EM_SDATA_LSB = EM_RD_LSB + RW;
  localparam int EM_ALU_LSB = EM_SDATA_LSB + XLEN;
  localparam int EM_CTRL_LSB = EM_ALU_LSB + XLEN;
  localparam int EM_W = 3 + XLEN * 2 + RW;

  // M/W: {wen, result, rd}
  localparam int MW_RD_LSB = 0;
  localparam int MW_RES_LSB = MW_RD_LSB + RW;
  localparam int MW_WEN_LSB = MW_RES_LSB + XLEN;
  localparam int MW_W = 1 + XLEN + RW;

  function automatic logic [FD_W-1:0] fd_nop();
    logic [FD_W-1:0] b;
    b = '0;
    b[FD_INSTR_LSB +: XLEN] = NOP_INSTR;
    return b;
  endfunction

  function automatic logic [DE_W-1:0] de_nop();
    logic [DE_W-1:0] b;
    b = '0;
    b[DE_INSTR_LSB +: XLEN] = NOP_INSTR;
    b[DE_CTRL_LSB +: 3] = CT_NONE;
    return b;
  endfunction

  function automatic logic [EM_W-1:0] em_nop();
    logic [EM_W-1:0] b;
    b = '0;
    b[EM_CTRL_LSB +: 3] = CT_NONE;
    return b;
  endfunction

  function automatic logic [MW_W-1:0] mw_nop();
    return '0;
  endfunction

endpackage

// File: rtl/pipe_stage_elastic_sat.sv
// Saturating event counter for pipeline performance debug.
// Holds at all-ones once full.
module sat_counter
  import rv_pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic full;

  assign full = &count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !full) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with two-entry skid buffer, flush,
// and saturating stall/bubble counters.
module pipe_stage_elastic
  import rv_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}},
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             s_valid;
  logic [WIDTH-1:0] s_data;
  logic             acc;
  logic             m_free;
  logic             stall_inc;
  logic             bubble_inc;

  assign in_ready = !s_valid;
  assign out_valid = m_valid;
  assign out_data = m_data;

  assign acc = in_valid && in_ready;
  assign m_free = !m_valid || out_ready;

  assign stall_inc = m_valid && !out_ready;
  assign bubble_inc = !m_valid;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      m_valid <= 1'b0;
      m_data <= NOP_VALUE;
      s_valid <= 1'b0;
      s_data <= NOP_VALUE;
    end else if (m_free) begin
      // skid always wins; in_ready is low while it is full
      if (s_valid) begin
        m_valid <= 1'b1;
        m_data <= s_data;
        s_valid <= 1'b0;
        s_data <= NOP_VALUE;
      end else if (acc) begin
        m_valid <= 1'b1;
        m_data <= in_data;
      end else begin
        m_valid <= 1'b0;
        m_data <= NOP_VALUE;
      end
    end else if (acc) begin
      s_valid <= 1'b1;
      s_data <= in_data;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall (
    .clk(clk),
    .reset(reset),
    .inc(stall_inc),
    .count(stall_cnt)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_bubble (
    .clk(clk),
    .reset(reset),
    .inc(bubble_inc),
    .count(bubble_cnt)
  );

endmodule

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Parametrised elastic pipeline register for the five-stage RV32 pipeline. It generalises the fixed Decode/Execute register bank to any payload width and adds a valid/ready handshake, synchronous flush with bubble (NOP) insertion, and a two-entry skid buffer so that `in_ready` is purely registered. It also provides saturating stall and bubble counters for performance debug. One instance sits between each pair of pipeline stages (F/D, D/E, E/M, M/W); the payload is the concatenated stage bundle.

## Interface
- `WIDTH`, default 32: payload width in bits; must be at least 1.
- `NOP_VALUE`, default `{WIDTH{1'b0}}`: value driven on `out_data` whenever `out_valid` is 0, and loaded into empty entries.
- `CNT_W`, default 16: width of each performance counter.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous flush; discards all held beats.
- `in_valid` in 1: upstream beat present.
- `in_data` in WIDTH: upstream payload.
- `in_ready` out 1: block can accept a beat this cycle; registered.
- `out_valid` out 1: downstream beat present.
- `out_data` out WIDTH: downstream payload; equals `NOP_VALUE` when `out_valid` is 0.
- `out_ready` in 1: downstream accepts the beat this cycle.
- `stall_cnt` out CNT_W: cycles with `out_valid && !out_ready`; saturating.
- `bubble_cnt` out CNT_W: cycles with `!out_valid`; saturating.

## Operation
- State: main entry (`m_valid`, `m_data`) and skid entry (`s_valid`, `s_data`). `out_valid = m_valid`, `out_data = m_data`, `in_ready = !s_valid`.
- Accept: `acc = in_valid && in_ready`. Drain: `drn = m_valid && out_ready`.
- Priority, evaluated per cycle, highest first:
  1. `reset`
  2. `flush`
  3. normal update.
- Reset: both valids are cleared, both data registers are loaded with `NOP_VALUE`, and both counters are set to 0.
- Flush: both valids are cleared and both data registers are loaded with `NOP_VALUE`. Any beat offered in the same cycle is discarded, even if `acc` is 1. The counters keep counting.
- Normal update:
  - Main empty or draining:
    - If `s_valid`, the skid entry moves to main and the skid is freed.
    - Otherwise, if `acc`, the input loads main.
    - Otherwise, main becomes empty and loads `NOP_VALUE`.
  - Accept in the skid-to-main case: `in_ready` is 0 whenever the skid is full, so `acc` cannot occur together with a skid-to-main move.
  - Main full and not draining, with `acc`: the input loads the skid.
- Ordering is strict FIFO. No beat is ever duplicated, and none is lost except by flush or reset.
- Counters are evaluated from the pre-edge state. Each increments by 1 when its condition holds and holds at `{CNT_W{1'b1}}` once saturated.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is visible on `out_*` after edge N.
- Throughput is 1 beat per cycle sustained while `out_ready` is 1.
- `in_ready` falls one cycle after the first stall cycle in which a beat is accepted. The skid absorbs that beat.
- `in_ready` rises the cycle after the skid drains into main.
- No combinational path exists from `out_ready` to `in_ready`. The only combinational input-to-output paths are the counter conditions, which feed registers only.
- Reset values of every output:
  - `in_ready` = 1
  - `out_valid` = 0
  - `out_data` = `NOP_VALUE`
  - `stall_cnt` = 0
  - `bubble_cnt` = 0
- `flush` asserted for k cycles: `out_valid` is 0 starting from the first edge and stays 0 until the first accept after `flush` is deasserted.
- Asserting `reset` mid-stall drops both held beats at the next edge.

## Structure
- The shared package `rv_pipe_pkg` holds:
  - stage-bundle widths, e.g. `DE_W = 3+32*5+5*3`, and the matching concatenation-order constants;
  - `NOP_INSTR = 32'h0000_0013` (`addi x0,x0,0`), used to build per-stage `NOP_VALUE` bundles.
- One sub-module, `sat_counter #(CNT_W)`, instantiated twice, provides the saturating counters.

## Test plan
- Reset: hold `reset` for 2 cycles with `in_valid`=1 and `in_data`=32'hDEAD_BEEF. Required: `out_valid`=0, `out_data`=`NOP_VALUE`, `in_ready`=1, and both counters 0.
- Streaming: feed 32'h1 to 32'h8 with `out_ready` held at 1. Required: outputs appear 1..8 in order, each 1 cycle after acceptance, and `in_ready` stays 1 throughout.
- Stall with skid fill: send A=32'hA, B=32'hB, C=32'hC with `out_ready`=0 from cycle 1.
  - Required: A is held in main, B is in the skid, `in_ready`=0, and C stays pending.
  - Release `out_ready`: the output sequence is A, B, C with no gaps or duplicates.
  - `stall_cnt` equals the number of stall cycles.
- Flush with simultaneous accept: main and skid both full, and `flush`=1 in the same cycle as `in_valid`=1 with 32'hF00D. Required: the next cycle has `out_valid`=0, `out_data`=`NOP_VALUE`, and `in_ready`=1, and 32'hF00D never appears on the output.
- Counter saturation: with `CNT_W`=4, idle for 20 cycles. Required: `bubble_cnt` holds at 4'hF.
- Width generality: with `WIDTH`=1 and `WIDTH`=199, a randomized valid/ready scoreboard run shows in-order, lossless delivery.
